// File: rtl/cr_iu_vector_fetch_if.sv
// rtl/cr_iu_vector_fetch_if.sv - instruction-bus fetch port between the vector fetch controller and the BMU
interface cr_iu_vector_fetch_if #(
   parameter int ADDR_W = 32
);
   logic              ibus_req;
   logic [ADDR_W-1:0] ibus_addr;
   logic              ibus_grnt;
   logic              ibus_data_vld;
   logic              ibus_acc_err;
   logic [ADDR_W-1:0] ibus_rdata;

   modport master (
      output ibus_req,
      output ibus_addr,
      input  ibus_grnt,
      input  ibus_data_vld,
      input  ibus_acc_err,
      input  ibus_rdata
   );

   modport slave (
      input  ibus_req,
      input  ibus_addr,
      output ibus_grnt,
      output ibus_data_vld,
      output ibus_acc_err,
      output ibus_rdata
   );
endinterface

// File: rtl/cr_iu_vector_fetch.sv
// rtl/cr_iu_vector_fetch.sv - hardware-vectored interrupt entry fetch controller
// Fetches the handler address from the vector table, retries bus failures, redirects pcgen.
module cr_iu_vector_fetch #(
   parameter int ADDR_W    = 32,
   parameter int ID_W      = 8,
   parameter int RETRY_MAX = 2,
   parameter int TIMEOUT_W = 8
) (
   input  logic                  misc_clk,
   input  logic                  cpurst_b,
   input  logic                  retire_vec_vld_i,
   input  logic                  retire_vec_hv_i,
   input  logic [ID_W-1:0]       retire_vec_id_i,
   input  logic                  wb_ldst_busy_i,
   input  logic                  ifu_ibus_idle_i,
   cr_iu_vector_fetch_if.master  ibus,
   input  logic [ADDR_W-3:0]     cp0_vbr_i,
   input  logic [ADDR_W-3:0]     cp0_err_vbr_i,
   input  logic [TIMEOUT_W-1:0]  cp0_timeout_i,
   input  logic                  pcgen_expt_taken_i,
   output logic                  fetch_mask_o,
   output logic                  ctrl_stall_o,
   output logic                  clk_en_o,
   output logic                  pcgen_chgflw_vld_o,
   output logic [ADDR_W-1:0]     pcgen_addr_o,
   output logic                  pcgen_buf_vbr_o,
   output logic                  cp0_vec_succeed_o,
   output logic                  cp0_vec_err_o,
   output logic [ADDR_W-1:0]     cp0_vec_err_epc_o
);

   localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

   typedef enum logic [3:0] {
      S_IDLE,
      S_NONVEC_WAIT,
      S_NONVEC_IDLE,
      S_BUF,
      S_WAIT_IDLE,
      S_WAIT_GRANT,
      S_WAIT_DATA,
      S_RETRY,
      S_VEC_ERR
   } state_e;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [ADDR_W-1:0]    entry_q, entry_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   logic [ADDR_W-1:0]    vbr_base;
   logic [ADDR_W-1:0]    err_base;
   logic [TIMEOUT_W:0]   tmo_cnt_inc;
   logic [TIMEOUT_W-1:0] tmo_cnt_sat;
   logic                 tmo_hit;
   logic                 fail;

   assign vbr_base    = {cp0_vbr_i, 2'b00};
   assign err_base    = {cp0_err_vbr_i, 2'b00};
   // Compare one bit wider so a saturated counter never aliases back onto the threshold.
   assign tmo_cnt_inc = {1'b0, tmo_cnt_q} + (TIMEOUT_W+1)'(1);
   assign tmo_cnt_sat = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_inc[TIMEOUT_W-1:0];
   assign tmo_hit     = (cp0_timeout_i != '0) && (tmo_cnt_inc == {1'b0, cp0_timeout_i});

   assign ibus.ibus_addr    = entry_q;
   assign cp0_vec_err_epc_o = entry_q;
   assign fetch_mask_o      = (state_q != S_IDLE);
   assign ctrl_stall_o      = (state_q != S_IDLE);
   assign clk_en_o          = (state_q != S_IDLE) | retire_vec_vld_i;

   always_comb begin
      state_d            = state_q;
      id_d               = id_q;
      entry_d            = entry_q;
      retry_d            = retry_q;
      tmo_cnt_d          = tmo_cnt_q;
      fail               = 1'b0;
      ibus.ibus_req      = 1'b0;
      pcgen_chgflw_vld_o = 1'b0;
      pcgen_addr_o       = '0;
      pcgen_buf_vbr_o    = 1'b0;
      cp0_vec_succeed_o  = 1'b0;
      cp0_vec_err_o      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (retire_vec_vld_i) begin
               if (retire_vec_hv_i) begin
                  state_d = S_BUF;
                  id_d    = retire_vec_id_i;
               end else begin
                  state_d = S_NONVEC_WAIT;
               end
            end
         end
         S_NONVEC_WAIT: begin
            if (!wb_ldst_busy_i) state_d = S_NONVEC_IDLE;
         end
         S_NONVEC_IDLE: begin
            if (pcgen_expt_taken_i) begin
               pcgen_chgflw_vld_o = 1'b1;
               pcgen_buf_vbr_o    = 1'b1;
               pcgen_addr_o       = vbr_base;
               state_d            = S_IDLE;
            end
         end
         S_BUF: begin
            entry_d = vbr_base + (ADDR_W'(id_q) << 2);
            retry_d = '0;
            if (!wb_ldst_busy_i) begin
               pcgen_buf_vbr_o = 1'b1;
               state_d         = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (ifu_ibus_idle_i) begin
               ibus.ibus_req = 1'b1;
               tmo_cnt_d     = '0;
               state_d       = ibus.ibus_grnt ? S_WAIT_DATA : S_WAIT_GRANT;
            end
         end
         S_WAIT_GRANT: begin
            ibus.ibus_req = 1'b1;
            if (ibus.ibus_grnt) begin
               tmo_cnt_d = '0;
               state_d   = S_WAIT_DATA;
            end else if (tmo_hit) begin
               fail = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_sat;
            end
         end
         S_WAIT_DATA: begin
            // Valid data outranks a simultaneous error or timeout.
            if (ibus.ibus_data_vld) begin
               pcgen_chgflw_vld_o = 1'b1;
               pcgen_addr_o       = {ibus.ibus_rdata[ADDR_W-1:1], 1'b0};
               cp0_vec_succeed_o  = 1'b1;
               state_d            = S_IDLE;
            end else if (ibus.ibus_acc_err || tmo_hit) begin
               fail = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_sat;
            end
         end
         S_RETRY: begin
            state_d = S_WAIT_IDLE;
         end
         S_VEC_ERR: begin
            pcgen_chgflw_vld_o = 1'b1;
            pcgen_buf_vbr_o    = 1'b1;
            pcgen_addr_o       = err_base;
            cp0_vec_err_o      = 1'b1;
            state_d            = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (fail) begin
         if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_RETRY;
         end else begin
            state_d = S_VEC_ERR;
         end
      end
   end

   always_ff @(posedge misc_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q   <= S_IDLE;
         id_q      <= '0;
         entry_q   <= '0;
         retry_q   <= '0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         entry_q   <= entry_d;
         retry_q   <= retry_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

endmodule

// File: tb/tb_cr_iu_vector_fetch.sv
// tb/tb_cr_iu_vector_fetch.sv - scoreboard bench for cr_iu_vector_fetch
module tb_cr_iu_vector_fetch;

   localparam int AW = 32;

   logic          misc_clk = 1'b0;
   logic          cpurst_b = 1'b0;
   logic          retire_vec_vld = 1'b0;
   logic          retire_vec_hv = 1'b0;
   logic [7:0]    retire_vec_id = '0;
   logic          wb_ldst_busy = 1'b0;
   logic          ifu_ibus_idle = 1'b1;
   logic [AW-3:0] cp0_vbr = '0;
   logic [AW-3:0] cp0_err_vbr = '0;
   logic [7:0]    cp0_timeout = '0;
   logic          pcgen_expt_taken = 1'b0;
   logic          fetch_mask, ctrl_stall, clk_en, pcgen_chgflw_vld, pcgen_buf_vbr;
   logic          cp0_vec_succeed, cp0_vec_err;
   logic [AW-1:0] pcgen_addr, cp0_vec_err_epc;

   cr_iu_vector_fetch_if #(.ADDR_W(AW)) ibus ();

   cr_iu_vector_fetch #(.ADDR_W(AW), .ID_W(8), .RETRY_MAX(2), .TIMEOUT_W(8)) dut (
      .misc_clk           (misc_clk),
      .cpurst_b           (cpurst_b),
      .retire_vec_vld_i   (retire_vec_vld),
      .retire_vec_hv_i    (retire_vec_hv),
      .retire_vec_id_i    (retire_vec_id),
      .wb_ldst_busy_i     (wb_ldst_busy),
      .ifu_ibus_idle_i    (ifu_ibus_idle),
      .ibus               (ibus),
      .cp0_vbr_i          (cp0_vbr),
      .cp0_err_vbr_i      (cp0_err_vbr),
      .cp0_timeout_i      (cp0_timeout),
      .pcgen_expt_taken_i (pcgen_expt_taken),
      .fetch_mask_o       (fetch_mask),
      .ctrl_stall_o       (ctrl_stall),
      .clk_en_o           (clk_en),
      .pcgen_chgflw_vld_o (pcgen_chgflw_vld),
      .pcgen_addr_o       (pcgen_addr),
      .pcgen_buf_vbr_o    (pcgen_buf_vbr),
      .cp0_vec_succeed_o  (cp0_vec_succeed),
      .cp0_vec_err_o      (cp0_vec_err),
      .cp0_vec_err_epc_o  (cp0_vec_err_epc)
   );

   always #5 misc_clk = ~misc_clk;

   int cyc = 0;
   always @(posedge misc_clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] addr;
      bit          buf_vbr;
      bit          succ;
      bit          err;
      logic [31:0] epc;
      int          at;
   } chg_t;

   typedef struct {
      bit          vld;
      bit          err;
      logic [31:0] data;
   } rsp_t;

   chg_t        chg_q[$];
   logic [31:0] req_q[$];
   rsp_t        rsp_q[$];
   bit          late_vld = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_chg(input logic [31:0] addr, input bit bv, input bit succ, input bit err,
                           input logic [31:0] epc, input int at);
      chg_t c;
      c.addr = addr; c.buf_vbr = bv; c.succ = succ; c.err = err; c.epc = epc; c.at = at;
      chg_q.push_back(c);
   endtask

   task automatic push_rsp(input bit vld, input bit err, input logic [31:0] data);
      rsp_t r;
      r.vld = vld; r.err = err; r.data = data;
      rsp_q.push_back(r);
   endtask

   task automatic step();
      @(posedge misc_clk);
      #1;
   endtask

   task automatic retire(input bit hv, input logic [7:0] id, output int k);
      retire_vec_vld = 1'b1;
      retire_vec_hv  = hv;
      retire_vec_id  = id;
      k = cyc;
      step();
      retire_vec_vld = 1'b0;
   endtask

   // Bus responder: a granted request gets the next planned response in the following cycle.
   initial begin
      bit   g;
      rsp_t r;
      ibus.ibus_data_vld = 1'b0;
      ibus.ibus_acc_err  = 1'b0;
      ibus.ibus_rdata    = '0;
      forever begin
         @(negedge misc_clk);
         g = ibus.ibus_req && ibus.ibus_grnt && cpurst_b;
         @(posedge misc_clk);
         #1;
         if (g && rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            ibus.ibus_data_vld = r.vld;
            ibus.ibus_acc_err  = r.err;
            ibus.ibus_rdata    = r.data;
         end else begin
            ibus.ibus_data_vld = late_vld;
            ibus.ibus_acc_err  = 1'b0;
            ibus.ibus_rdata    = 32'hDEAD_BEEF;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT issues a granted request or a redirect.
   initial begin
      chg_t        c;
      logic [31:0] e;
      forever begin
         @(negedge misc_clk);
         if (cpurst_b) begin
            if (ibus.ibus_req && ibus.ibus_grnt) begin
               if (req_q.size() == 0) begin
                  check("req_unexpected", ibus.ibus_req, 0);
               end else begin
                  e = req_q.pop_front();
                  check("req_addr", ibus.ibus_addr, e);
               end
            end
            if (pcgen_chgflw_vld) begin
               if (chg_q.size() == 0) begin
                  check("chgflw_unexpected", pcgen_chgflw_vld, 0);
               end else begin
                  c = chg_q.pop_front();
                  check("chg_addr", pcgen_addr, c.addr);
                  check("chg_buf_vbr", pcgen_buf_vbr, c.buf_vbr);
                  check("chg_succeed", cp0_vec_succeed, c.succ);
                  check("chg_vec_err", cp0_vec_err, c.err);
                  if (c.err) check("chg_err_epc", cp0_vec_err_epc, c.epc);
                  if (c.at >= 0) check("chg_cycle", cyc, c.at);
               end
            end else begin
               check("pulse_alone", {cp0_vec_succeed, cp0_vec_err}, 0);
            end
         end
      end
   end

   initial begin
      int k;
      bit mask_all;
      ibus.ibus_grnt = 1'b1;
      cp0_vbr        = 30'h1000_0000;
      cp0_err_vbr    = 30'h0800_0000;

      repeat (3) @(posedge misc_clk);
      @(negedge misc_clk);
      check("rst_ctrl", {ibus.ibus_req, pcgen_chgflw_vld, pcgen_buf_vbr, cp0_vec_succeed,
                         cp0_vec_err, fetch_mask, ctrl_stall, clk_en}, 0);
      check("rst_ibus_addr", ibus.ibus_addr, 0);
      check("rst_pcgen_addr", pcgen_addr, 0);
      check("rst_epc", cp0_vec_err_epc, 0);
      step();
      cpurst_b = 1'b1;
      step();

      // Minimum latency fetch, id 5.
      req_q.push_back(32'h4000_0014);
      push_rsp(1, 0, 32'h1234_5679);
      push_chg(32'h1234_5678, 0, 1, 0, 0, cyc + 3);
      retire_vec_vld = 1'b1; retire_vec_hv = 1'b1; retire_vec_id = 8'd5;
      #1;
      check("clk_en_on_retire", clk_en, 1);
      step();
      retire_vec_vld = 1'b0;
      check("buf_vbr_pulse", pcgen_buf_vbr, 1);
      check("buf_fetch_mask", fetch_mask, 1);
      repeat (6) step();

      // Non-vectored exception.
      retire_vec_vld = 1'b1; retire_vec_hv = 1'b0; wb_ldst_busy = 1'b1;
      k = cyc;
      push_chg(32'h4000_0000, 1, 0, 0, 0, k + 7);
      mask_all = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 1) retire_vec_vld = 1'b0;
         if (i == 5) wb_ldst_busy = 1'b0;
         if (i == 7) pcgen_expt_taken = 1'b1;
         if (i == 8) pcgen_expt_taken = 1'b0;
         if (i <= 7) mask_all = mask_all & fetch_mask & ctrl_stall;
      end
      check("nonvec_mask_held", mask_all, 1);
      check("nonvec_back_idle", fetch_mask, 0);
      step();

      // Two access errors then success.
      repeat (3) req_q.push_back(32'h4000_0004);
      push_rsp(0, 1, 0);
      push_rsp(0, 1, 0);
      push_rsp(1, 0, 32'h8000_0001);
      push_chg(32'h8000_0000, 0, 1, 0, 0, -1);
      retire(1, 8'd1, k);
      repeat (20) step();

      // All three attempts fail.
      repeat (3) req_q.push_back(32'h4000_0008);
      repeat (3) push_rsp(0, 1, 0);
      push_chg(32'h2000_0000, 1, 0, 1, 32'h4000_0008, -1);
      retire(1, 8'd2, k);
      repeat (20) step();
      check("epc_hold", cp0_vec_err_epc, 32'h4000_0008);

      // Grant timeout of 3 cycles on every attempt.
      cp0_timeout    = 8'd3;
      ibus.ibus_grnt = 1'b0;
      retire_vec_vld = 1'b1; retire_vec_hv = 1'b1; retire_vec_id = 8'd3;
      k = cyc;
      push_chg(32'h2000_0000, 1, 0, 1, 32'h4000_000C, k + 16);
      step();
      retire_vec_vld = 1'b0;
      repeat (4) @(posedge misc_clk);
      @(negedge misc_clk);
      check("tmo_req_third_wait", ibus.ibus_req, 1);
      @(negedge misc_clk);
      check("tmo_retry_gap", ibus.ibus_req, 0);
      @(negedge misc_clk);
      check("tmo_req_again", ibus.ibus_req, 1);
      repeat (12) step();
      check("tmo_back_idle", fetch_mask, 0);

      // Timeout disabled: request held until a late grant.
      cp0_timeout = 8'd0;
      retire(1, 8'd4, k);
      repeat (40) step();
      check("notmo_req_held", ibus.ibus_req, 1);
      check("notmo_mask_held", fetch_mask, 1);
      req_q.push_back(32'h4000_0010);
      push_rsp(1, 0, 32'h0000_2001);
      push_chg(32'h0000_2000, 0, 1, 0, 0, -1);
      ibus.ibus_grnt = 1'b1;
      repeat (5) step();

      // Entry address wraps.
      cp0_vbr = 30'h3FFF_FFFC;
      req_q.push_back(32'h0000_0010);
      push_rsp(1, 0, 32'h0000_0101);
      push_chg(32'h0000_0100, 0, 1, 0, 0, cyc + 3);
      retire(1, 8'd8, k);
      repeat (6) step();

      // Data valid together with access error counts as success.
      cp0_vbr = 30'h1000_0000;
      req_q.push_back(32'h4000_0018);
      push_rsp(1, 1, 32'h3000_0003);
      push_chg(32'h3000_0002, 0, 1, 0, 0, -1);
      retire(1, 8'd6, k);
      repeat (8) step();

      // Reset while waiting for data; a late response must be ignored.
      req_q.push_back(32'h4000_001C);
      retire(1, 8'd7, k);
      step();
      step();
      cpurst_b = 1'b0;
      #1;
      check("midrst_ctrl", {ibus.ibus_req, pcgen_chgflw_vld, pcgen_buf_vbr, cp0_vec_succeed,
                            cp0_vec_err, fetch_mask, ctrl_stall, clk_en}, 0);
      check("midrst_ibus_addr", ibus.ibus_addr, 0);
      check("midrst_pcgen_addr", pcgen_addr, 0);
      check("midrst_epc", cp0_vec_err_epc, 0);
      step();
      cpurst_b = 1'b1;
      late_vld = 1'b1;
      step();
      step();
      late_vld = 1'b0;
      repeat (3) step();
      check("midrst_idle", fetch_mask, 0);

      check("chg_queue_drained", chg_q.size(), 0);
      check("req_queue_drained", req_q.size(), 0);
      check("rsp_queue_drained", rsp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
